alu_operand_fetch: RTL and testbench

Operand-fetch and issue stage that sits directly upstream of `alu`. It holds an 8-entry register file and accepts instructions over a valid/ready handshake. It drives registered `operand1`/`operand2`/`opCode` into the combinational ALU and writes `result`/`carryOut` back into the register file and a carry flag. An external load port initialises registers.

---
 rtl/alu_operand_fetch.sv | 128 ++++++++++++
 tb/tb_alu_operand_fetch.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_operand_fetch.sv
// Operand-fetch / issue stage feeding a combinational ALU: 8-entry register file,
// execute register and writeback. Define ALU_OPERAND_FORWARD_EN for 1/cycle issue with forwarding.
//
// state | meaning
// IDLE  | execute register empty or retiring; may accept an instruction
// EXEC  | instruction on ALU inputs; retires on this edge, no accept
module alu_operand_fetch #(
    parameter int WORD_WIDTH     = 8,
    parameter int OPCODE_WIDTH   = 4,
    parameter int REG_ADDR_WIDTH = 3
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic                      instrValid,
    output logic                      instrReady,
    input  logic [OPCODE_WIDTH-1:0]   instrOpCode,
    input  logic [REG_ADDR_WIDTH-1:0] instrRd,
    input  logic [REG_ADDR_WIDTH-1:0] instrRs1,
    input  logic [REG_ADDR_WIDTH-1:0] instrRs2,
    input  logic                      loadValid,
    input  logic [REG_ADDR_WIDTH-1:0] loadAddr,
    input  logic [WORD_WIDTH-1:0]     loadData,
    output logic [WORD_WIDTH-1:0]     operand1,
    output logic [WORD_WIDTH-1:0]     operand2,
    output logic [OPCODE_WIDTH-1:0]   opCode,
    output logic                      execValid,
    input  logic [WORD_WIDTH-1:0]     aluResult,
    input  logic                      aluCarryOut,
    output logic                      carryFlag,
    input  logic [REG_ADDR_WIDTH-1:0] dbgAddr,
    output logic [WORD_WIDTH-1:0]     dbgData
);

    localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

    logic [WORD_WIDTH-1:0]     r_regFile [NUM_REGS];
    logic [WORD_WIDTH-1:0]     r_operand1;
    logic [WORD_WIDTH-1:0]     r_operand2;
    logic [OPCODE_WIDTH-1:0]   r_opCode;
    logic [REG_ADDR_WIDTH-1:0] r_rdE;
    logic                      r_execValid;
    logic                      r_carryFlag;

    logic                      w_ready;
    logic                      w_accept;
    logic [WORD_WIDTH-1:0]     w_src1;
    logic [WORD_WIDTH-1:0]     w_src2;

`ifdef ALU_OPERAND_FORWARD_EN
    logic w_fwd1;
    logic w_fwd2;

    assign w_ready = !loadValid;
    assign w_fwd1  = r_execValid && (instrRs1 == r_rdE);
    assign w_fwd2  = r_execValid && (instrRs2 == r_rdE);
    // The result retiring on this edge is the newest value of rdE
    assign w_src1  = w_fwd1 ? aluResult : r_regFile[instrRs1];
    assign w_src2  = w_fwd2 ? aluResult : r_regFile[instrRs2];
`else
    localparam logic [0:0] IDLE = 1'b0;
    localparam logic [0:0] EXEC = 1'b1;

    logic [0:0] r_state;
    logic [0:0] w_stateNext;

    always_comb begin
        w_stateNext = r_state;
        case (r_state)
            IDLE:    if (w_accept) w_stateNext = EXEC;
            EXEC:    w_stateNext = IDLE;
            default: w_stateNext = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) r_state <= IDLE;
        else       r_state <= w_stateNext;
    end

    assign w_ready = (r_state == IDLE) && !loadValid;
    assign w_src1  = r_regFile[instrRs1];
    assign w_src2  = r_regFile[instrRs2];
`endif

    assign w_accept = instrValid && w_ready;

    // Load is written after the retire so it wins on an address collision
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) r_regFile[i] <= '0;
        end else begin
            if (r_execValid) r_regFile[r_rdE] <= aluResult;
            if (loadValid)   r_regFile[loadAddr] <= loadData;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_operand1  <= '0;
            r_operand2  <= '0;
            r_opCode    <= '0;
            r_rdE       <= '0;
            r_execValid <= 1'b0;
        end else if (w_accept) begin
            r_operand1  <= w_src1;
            r_operand2  <= w_src2;
            r_opCode    <= instrOpCode;
            r_rdE       <= instrRd;
            r_execValid <= 1'b1;
        end else begin
            r_execValid <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset)            r_carryFlag <= 1'b0;
        else if (r_execValid) r_carryFlag <= aluCarryOut;
    end

    assign instrReady = w_ready;
    assign operand1   = r_operand1;
    assign operand2   = r_operand2;
    assign opCode     = r_opCode;
    assign execValid  = r_execValid;
    assign carryFlag  = r_carryFlag;
    assign dbgData    = r_regFile[dbgAddr];

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Bench for alu_operand_fetch with an adder ALU stub; program-order register model
// feeds a scoreboard of expected operands checked whenever execValid is seen.
module tb_alu_operand_fetch;

    logic       clk = 1'b0;
    logic       reset;
    logic       instrValid;
    logic       instrReady;
    logic [3:0] instrOpCode;
    logic [2:0] instrRd, instrRs1, instrRs2;
    logic       loadValid;
    logic [2:0] loadAddr;
    logic [7:0] loadData;
    logic [7:0] operand1, operand2;
    logic [3:0] opCode;
    logic       execValid;
    logic [7:0] aluResult;
    logic       aluCarryOut;
    logic       carryFlag;
    logic [2:0] dbgAddr;
    logic [7:0] dbgData;

    always #5 clk = ~clk;

    assign {aluCarryOut, aluResult} = {1'b0, operand1} + {1'b0, operand2};

    alu_operand_fetch dut (
        .clk(clk), .reset(reset),
        .instrValid(instrValid), .instrReady(instrReady), .instrOpCode(instrOpCode),
        .instrRd(instrRd), .instrRs1(instrRs1), .instrRs2(instrRs2),
        .loadValid(loadValid), .loadAddr(loadAddr), .loadData(loadData),
        .operand1(operand1), .operand2(operand2), .opCode(opCode), .execValid(execValid),
        .aluResult(aluResult), .aluCarryOut(aluCarryOut), .carryFlag(carryFlag),
        .dbgAddr(dbgAddr), .dbgData(dbgData)
    );

    typedef struct packed {
        logic [7:0] op1;
        logic [7:0] op2;
        logic [3:0] opc;
        logic       carry;
    } exp_t;

    exp_t       q[$];
    logic [7:0] m_rf [8];
    int         n_checks = 0;
    int         n_fail   = 0;
    logic       carry_pend = 1'b0;
    logic       carry_exp  = 1'b0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Negedge monitor: operands of each issued instruction, then carry after its retire
    always @(negedge clk) begin
        exp_t e;
        if (carry_pend) begin
            chk("carry", {31'b0, carryFlag}, {31'b0, carry_exp});
            carry_pend = 1'b0;
        end
        if (execValid === 1'b1) begin
            if (q.size() == 0) begin
                chk("sb_depth", q.size(), 1);
            end else begin
                e = q.pop_front();
                chk("operand1", {24'b0, operand1}, {24'b0, e.op1});
                chk("operand2", {24'b0, operand2}, {24'b0, e.op2});
                chk("opcode",   {28'b0, opCode},   {28'b0, e.opc});
                if (reset !== 1'b1) begin
                    carry_pend = 1'b1;
                    carry_exp  = e.carry;
                end
            end
        end
    end

    task automatic load(input logic [2:0] addr, input logic [7:0] data);
        loadValid = 1'b1;
        loadAddr  = addr;
        loadData  = data;
        m_rf[addr] = data;
        @(posedge clk); #1;
        loadValid = 1'b0;
    endtask

    task automatic issue(input logic [3:0] opc, input logic [2:0] rd, input logic [2:0] rs1,
                         input logic [2:0] rs2, output int waits);
        exp_t       e;
        logic [8:0] s;
        instrOpCode = opc;
        instrRd     = rd;
        instrRs1    = rs1;
        instrRs2    = rs2;
        instrValid  = 1'b1;
        waits       = 0;
        #1;
        while (instrReady !== 1'b1 && waits < 8) begin
            @(posedge clk); #1;
            waits++;
            #1;
        end
        if (instrReady !== 1'b1) begin
            chk("issue_ready", {31'b0, instrReady}, 1);
            instrValid = 1'b0;
            return;
        end
        s       = {1'b0, m_rf[rs1]} + {1'b0, m_rf[rs2]};
        e.op1   = m_rf[rs1];
        e.op2   = m_rf[rs2];
        e.opc   = opc;
        e.carry = s[8];
        q.push_back(e);
        m_rf[rd] = s[7:0];
        @(posedge clk); #1;
        instrValid = 1'b0;
    endtask

    task automatic check_rf(input string tag);
        for (int i = 0; i < 8; i++) begin
            dbgAddr = i[2:0];
            #1;
            chk(tag, {24'b0, dbgData}, {24'b0, m_rf[i]});
        end
    endtask

    task automatic drain();
        @(posedge clk); #1;
        @(posedge clk); #1;
    endtask

    initial begin
        int w;
        int w2;
        reset = 1'b1; instrValid = 1'b0; instrOpCode = '0; instrRd = '0;
        instrRs1 = '0; instrRs2 = '0; loadValid = 1'b0; loadAddr = '0;
        loadData = '0; dbgAddr = '0;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;

        // Reset values
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        chk("rst_execValid", {31'b0, execValid}, 0);
        chk("rst_carry",     {31'b0, carryFlag}, 0);
        chk("rst_ready",     {31'b0, instrReady}, 1);
        @(posedge clk); #1;
        check_rf("rst_rf");
        @(posedge clk); #1;

        // Load then add
        load(3'd1, 8'h05);
        load(3'd2, 8'h07);
        issue(4'h0, 3'd3, 3'd1, 3'd2, w);
        chk("add_op1_lat", {24'b0, operand1}, 32'h05);
        chk("add_op2_lat", {24'b0, operand2}, 32'h07);
        @(posedge clk); #1;
        dbgAddr = 3'd3; #1;
        chk("add_r3_wb", {24'b0, dbgData}, 32'h0C);
        chk("add_carry", {31'b0, carryFlag}, 0);
        drain();

        // Carry
        load(3'd1, 8'hF0);
        load(3'd2, 8'h20);
        issue(4'h1, 3'd4, 3'd1, 3'd2, w);
        drain();
        dbgAddr = 3'd4; #1;
        chk("carry_r4", {24'b0, dbgData}, 32'h10);
        chk("carry_flag", {31'b0, carryFlag}, 1);
        check_rf("carry_rf");
        @(posedge clk); #1;

        // Dependent back-to-back
        load(3'd1, 8'h05);
        load(3'd2, 8'h07);
        issue(4'h2, 3'd3, 3'd1, 3'd2, w);
        #1;
`ifdef ALU_OPERAND_FORWARD_EN
        chk("dep_ready_gap", {31'b0, instrReady}, 1);
        issue(4'h3, 3'd5, 3'd3, 3'd3, w2);
        chk("dep_waits", w2, 0);
`else
        chk("dep_ready_gap", {31'b0, instrReady}, 0);
        issue(4'h3, 3'd5, 3'd3, 3'd3, w2);
        chk("dep_waits", w2, 1);
`endif
        drain();
        dbgAddr = 3'd5; #1;
        chk("dep_r5", {24'b0, dbgData}, 32'h18);
        check_rf("dep_rf");
        @(posedge clk); #1;

        // Load and issue in the same cycle: instruction waits one cycle
        loadValid = 1'b1; loadAddr = 3'd6; loadData = 8'h33;
        instrOpCode = 4'h4; instrRd = 3'd7; instrRs1 = 3'd6; instrRs2 = 3'd1; instrValid = 1'b1;
        #1;
        chk("ld_issue_ready", {31'b0, instrReady}, 0);
        m_rf[6] = 8'h33;
        @(posedge clk); #1;
        loadValid = 1'b0;
        issue(4'h4, 3'd7, 3'd6, 3'd1, w);
        chk("ld_issue_waits", w, 0);
        drain();
        dbgAddr = 3'd7; #1;
        chk("ld_issue_r7", {24'b0, dbgData}, 32'h38);

        // Load to rdE on the retire edge: load wins
        @(posedge clk); #1;
        issue(4'h5, 3'd3, 3'd1, 3'd2, w);
        loadValid = 1'b1; loadAddr = 3'd3; loadData = 8'hAA;
        m_rf[3] = 8'hAA;
        @(posedge clk); #1;
        loadValid = 1'b0;
        dbgAddr = 3'd3; #1;
        chk("ld_retire_r3", {24'b0, dbgData}, 32'hAA);
        drain();
        check_rf("ld_retire_rf");
        @(posedge clk); #1;

        // Mixed random traffic against the program-order model
        for (int k = 0; k < 24; k++) begin
            if ($urandom_range(2) == 0)
                load(3'($urandom_range(7)), 8'($urandom_range(255)));
            else
                issue(4'($urandom_range(15)), 3'($urandom_range(7)), 3'($urandom_range(7)),
                      3'($urandom_range(7)), w);
        end
        drain();
        check_rf("rand_rf");
        @(posedge clk); #1;

        // Reset with an instruction in flight: no retire
        load(3'd1, 8'hC0);
        load(3'd2, 8'h50);
        issue(4'h6, 3'd6, 3'd1, 3'd2, w);
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        for (int i = 0; i < 8; i++) m_rf[i] = 8'h00;
        #1;
        chk("midrst_execValid", {31'b0, execValid}, 0);
        chk("midrst_carry",     {31'b0, carryFlag}, 0);
        chk("midrst_ready",     {31'b0, instrReady}, 1);
        dbgAddr = 3'd6; #1;
        chk("midrst_r6", {24'b0, dbgData}, 32'h00);
        @(posedge clk); #1;
        check_rf("midrst_rf");
        @(posedge clk); #1;

        // Stage still works after reset
        load(3'd0, 8'h81);
        issue(4'h7, 3'd2, 3'd0, 3'd0, w);
        drain();
        check_rf("post_rst_rf");
        chk("post_rst_carry", {31'b0, carryFlag}, 1);

        chk("sb_left", q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
